fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32 core.
- Owns PCF and issues requests to a variable-latency instruction memory.
- Absorbs responses that arrive while Decode is stalled.
- Applies Execute-stage redirects and presents PC, instruction, PC+4 and a valid bit to Decode.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, InstrD value when the IF/ID register is empty or flushed (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- StallD  in  1  Decode cannot accept; hold IF/ID
- FlushD  in  1  squash IF/ID contents
- PCSrcE  in  1  redirect from Execute (taken branch/jump)
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address (equals PCF)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid (in-order, never backpressured)
- imem_rdata  in  XLEN  response instruction
- PCF  out  XLEN  current fetch PC
- InstrF  out  XLEN  instruction being written into IF/ID this cycle (imem_rdata or hold buffer), else NOP_INSTR
- ValidD  out  1  IF/ID holds a real instruction
- InstrD  out  XLEN  IF/ID instruction
- PCD  out  XLEN  IF/ID PC
- PCPlus4D  out  XLEN  PCD+4

Behaviour:
- Reset values: PCF=RESET_PC, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, hold buffer empty, state=IDLE, imem_req=0.
- At most one outstanding request. pc_out records the address of the in-flight request.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DROP: request outstanding, response is to be discarded.
- imem_req=1 when all of the following hold:
  - reset is low and PCSrcE=0;
  - hold buffer is empty;
  - state is IDLE, or state is WAIT with imem_rvalid=1 and the response is delivered to IF/ID this cycle.
- Accept (imem_req & imem_ready): pc_out<=PCF, PCF<=PCF+4 (mod 2^XLEN), state->WAIT.
- Response in WAIT:
  - If IF/ID can load (ValidD=0 or StallD=0), load IF/ID.
  - Otherwise, write the response into the hold buffer (instr, pc).
  - State->IDLE, unless a new request is accepted in the same cycle (state stays WAIT).
- Response in DROP: discarded, state->IDLE. A request may not be issued in that same cycle.
- Response in IDLE: ignored (a stale response after reset).
- IF/ID load priority: hold buffer first, then the live response. The hold buffer drains as soon as StallD=0.
- StallD=1 and FlushD=0: IF/ID is unchanged.
- FlushD=1: ValidD<=0 and InstrD<=NOP_INSTR next edge. Flush wins over stall and over a load.
- PCSrcE=1 (priority over everything):
  - PCF<=PCTargetE.
  - IF/ID is flushed.
  - Hold buffer is cleared.
  - WAIT->DROP, unless imem_rvalid=1 this cycle (response discarded, ->IDLE).
  - No request is issued this cycle.
- Latency with single-cycle memory (ready=1, rvalid the cycle after accept): request cycle N, response N+1, ValidD in N+2. Throughput is 1 instruction/cycle.
- Asynchronous reset at any time returns all state to reset values immediately. The first request is issued in the first cycle after reset deasserts.
- PCTargetE misalignment is not checked; PCF increments by 4 without overflow detection (wraps).

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DROP};
  - NOP_INSTR constant;
  - XLEN default.
- Sub-module fetch_hold_buf: a 1-entry {instr, pc} skid register with write, read and clear ports and a full flag.

Test Plan:
- Reset held 22 ns, single-cycle memory returning a program: first request at PCF=0; ValidD=1 with PCD=0 two cycles later; PCF reaches 160 after 40 accepts with no bubbles.
- imem_ready low for 3 cycles at PCF=8 -> imem_req stays high, PCF holds at 8; no duplicate or skipped PCD.
- StallD=1 for 4 cycles while a response arrives -> the response is captured in the hold buffer and requests stop; after StallD falls, PCD sequence is 0x10, 0x14, 0x18 with nothing lost.
- PCSrcE=1, PCTargetE=0x40 with a request in flight (3-cycle latency) -> that response is discarded and ValidD=0; the next request address is 0x40 and the next PCD is 0x40.
- FlushD and StallD asserted together -> ValidD=0 and InstrD=0x00000013 next cycle.
- reset asserted in WAIT, stale imem_rvalid arriving after reset -> ignored; PCF=0 and ValidD=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE,  // nothing outstanding
    WAIT,  // response outstanding and wanted
    DROP   // response outstanding but stale after a redirect
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register holding an instruction whose response arrived
// while Decode was stalled.
module fetch_hold_buf #(
  parameter int XLEN = fetch_pkg::DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            write,
  input  logic            read,
  input  logic [XLEN-1:0] new_instr,
  input  logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      full <= 1'b0;
    else if (clear) full <= 1'b0;
    else if (write) full <= 1'b1;
    else if (read)  full <= 1'b0;
  end

  // NOTE: payload is qualified by full, so it carries no reset and stays a plain register.
  always_ff @(posedge clk) begin
    if (write && !clear) begin
      instr <= new_instr;
      pc    <= new_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding imem request, a stall skid
// buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter int              XLEN      = fetch_pkg::DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrF,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  import fetch_pkg::*;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] hold_instr, hold_pc;
  logic            hold_full;
  logic            can_load, resp_wait;
  logic            load_hold, load_resp, park_resp, accept;

  assign can_load  = !ValidD || !StallD;
  assign resp_wait = (state == WAIT) && imem_rvalid;
  // A redirect kills everything in flight, so it vetoes every load/park path.
  assign load_hold = hold_full && can_load && !PCSrcE;
  assign load_resp = resp_wait && !hold_full && can_load && !PCSrcE;
  assign park_resp = resp_wait && !can_load && !PCSrcE;
  assign accept    = imem_req && imem_ready;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clear    (PCSrcE),
    .write    (park_resp),
    .read     (load_hold),
    .new_instr(imem_rdata),
    .new_pc   (pc_out),
    .instr    (hold_instr),
    .pc       (hold_pc),
    .full     (hold_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = WAIT;
      WAIT: begin
        if (PCSrcE)           state_next = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_next = accept ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = !reset && !PCSrcE && !hold_full && ((state == IDLE) || load_resp);
    imem_addr = PCF;
    InstrF    = NOP_INSTR;
    if (load_hold)      InstrF = hold_instr;
    else if (load_resp) InstrF = imem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF    <= RESET_PC;
      pc_out <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= PCTargetE;
    end else if (accept) begin
      PCF    <= PCF + XLEN'(4);
      pc_out <= PCF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE || FlushD) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end else if (load_hold) begin
      ValidD   <= 1'b1;
      InstrD   <= hold_instr;
      PCD      <= hold_pc;
      PCPlus4D <= hold_pc + XLEN'(4);
    end else if (load_resp) begin
      ValidD   <= 1'b1;
      InstrD   <= imem_rdata;
      PCD      <= pc_out;
      PCPlus4D <= pc_out + XLEN'(4);
    end else if (!StallD) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural imem with programmable latency, a
// stream-level model of fetch order and Decode order, and directed scenarios.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req, imem_ready = 1'b1, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrF(InstrF), .ValidD(ValidD), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  // Instruction memory: one request slot, response 'lat' cycles after accept.
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  initial begin : imem
    logic        acc;
    logic [31:0] acc_addr;
    forever begin
      @(negedge clk); #4;
      acc      = imem_req && imem_ready && !reset;
      acc_addr = imem_addr;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (acc) begin
        mem_pend = 1'b1;
        mem_cnt  = lat;
        mem_addr = acc_addr;
      end
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(mem_addr);
          mem_pend    = 1'b0;
        end
      end
    end
  end

  // Stream model: fetch addresses advance by 4 per accept, Decode sees
  // consecutive PCs, both restart at a redirect target or after reset.
  initial begin : compare
    logic [31:0] exp_fetch, exp_id, prev_instrf;
    logic        prev_kill;
    exp_fetch = '0; exp_id = '0; prev_instrf = NOP; prev_kill = 1'b1;
    forever begin
      @(negedge clk); #4;
      if (reset) begin
        check("rst_pcf", PCF, 32'h0);
        check("rst_valid", 32'(ValidD), 32'h0);
        check("rst_instrd", InstrD, NOP);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pcplus4d", PCPlus4D, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        exp_fetch = '0; exp_id = '0; prev_instrf = NOP; prev_kill = 1'b1;
      end else begin
        check("pcf", PCF, exp_fetch);
        check("imem_addr", imem_addr, exp_fetch);
        if (!ValidD) check("empty_is_nop", InstrD, NOP);
        if (!prev_kill && prev_instrf != NOP) begin
          check("instrf_landed_valid", 32'(ValidD), 32'h1);
          check("instrf_landed", InstrD, prev_instrf);
        end
        if (mem_pend) check("single_outstanding", 32'(imem_req), 32'h0);
        if (PCSrcE) begin
          check("no_req_on_redirect", 32'(imem_req), 32'h0);
          exp_fetch = PCTargetE;
          exp_id    = PCTargetE;
        end else begin
          if (imem_req && imem_ready) exp_fetch += 32'd4;
          if (ValidD && (!StallD || FlushD)) begin
            check("pcd_order", PCD, exp_id);
            check("instrd", InstrD, instr_of(exp_id));
            check("pcplus4d", PCPlus4D, exp_id + 32'd4);
            exp_id += 32'd4;
          end
        end
        prev_instrf = InstrF;
        prev_kill   = PCSrcE || FlushD;
      end
    end
  end

  task automatic do_reset(input int new_lat);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 lat = new_lat;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ValidD && n < limit);
    check(name, 32'(ValidD), 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    // Power-on reset for 22 ns, single-cycle memory.
    #22 reset = 1'b0;
    #2;
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("resp_cycle_valid", 32'(ValidD), 32'h0);
    check("resp_cycle_instrf", InstrF, instr_of(32'h0));
    @(posedge clk); #1 imem_ready = 1'b0;
    @(negedge clk);
    check("first_validd", 32'(ValidD), 32'h1);
    check("first_pcd", PCD, 32'h0);
    check("first_pcplus4d", PCPlus4D, 32'h4);
    check("pcf_at_stall", PCF, 32'h8);
    repeat (2) @(negedge clk);
    check("req_held_not_ready", 32'(imem_req), 32'h1);
    check("pcf_held_not_ready", PCF, 32'h8);
    @(posedge clk); #1 imem_ready = 1'b1;
    repeat (39) @(negedge clk);
    check("pcf_after_40", PCF, 32'd160);

    // Decode stall while a response lands: skid buffer then drain.
    do_reset(1);
    repeat (6) @(posedge clk);
    #1 StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_pcd", PCD, 32'h10);
      check("stall_no_req", 32'(imem_req), 32'h0);
    end
    @(posedge clk); #1 StallD = 1'b0;
    @(negedge clk); check("drain_pcd0", PCD, 32'h10);
    @(negedge clk); check("drain_pcd1", PCD, 32'h14);
    @(negedge clk); check("drain_bubble", 32'(ValidD), 32'h0);
    @(negedge clk); check("drain_pcd2", PCD, 32'h18);

    // Redirect with a 3-cycle request in flight.
    do_reset(3);
    @(posedge clk); #1 PCSrcE = 1'b1; PCTargetE = 32'h40;
    @(negedge clk); check("redir_no_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1 PCSrcE = 1'b0;
    @(negedge clk);
    check("redir_pcf", PCF, 32'h40);
    check("redir_drop_no_req", 32'(imem_req), 32'h0);
    check("redir_valid", 32'(ValidD), 32'h0);
    @(negedge clk);
    check("drop_resp_no_req", 32'(imem_req), 32'h0);
    check("drop_resp_instrf", InstrF, NOP);
    check("drop_resp_valid", 32'(ValidD), 32'h0);
    @(negedge clk);
    check("redir_req", 32'(imem_req), 32'h1);
    check("redir_addr", imem_addr, 32'h40);
    wait_valid("redir_valid_timeout", 10);
    check("redir_pcd", PCD, 32'h40);

    // Redirect in the same cycle as a wanted response.
    do_reset(1);
    repeat (5) @(posedge clk);
    #1 PCSrcE = 1'b1; PCTargetE = 32'h200;
    @(negedge clk); check("redir2_no_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1 PCSrcE = 1'b0;
    @(negedge clk);
    check("redir2_req", 32'(imem_req), 32'h1);
    check("redir2_addr", imem_addr, 32'h200);
    check("redir2_valid", 32'(ValidD), 32'h0);
    @(negedge clk); check("redir2_bubble", 32'(ValidD), 32'h0);
    @(negedge clk); check("redir2_pcd", PCD, 32'h200);

    // Flush together with stall.
    repeat (3) @(posedge clk);
    #1 StallD = 1'b1; FlushD = 1'b1;
    @(posedge clk); #1 StallD = 1'b0; FlushD = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(ValidD), 32'h0);
    check("flush_instrd", InstrD, NOP);
    repeat (3) @(negedge clk);

    // Reset during WAIT; the stale response must be ignored.
    do_reset(3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("stale_valid", 32'(ValidD), 32'h0);
    check("stale_pcf", PCF, 32'h0);
    check("stale_instrf", InstrF, NOP);
    check("stale_req", 32'(imem_req), 32'h1);
    @(negedge clk);
    check("stale_after_valid", 32'(ValidD), 32'h0);
    check("stale_after_pcf", PCF, 32'h4);
    wait_valid("post_reset_valid_timeout", 10);
    check("post_reset_pcd", PCD, 32'h0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
